// File: rtl/chess_board_renderer_pkg.sv
// Shared definitions for the chess board renderer: chessman codes, layout
// byte bit positions, RGB565 palette and the frame FSM state encoding.
package chess_render_pkg;

   typedef enum logic [2:0] {
      EMPTY  = 3'd0,
      PAWN   = 3'd1,
      KNIGHT = 3'd2,
      ROOK   = 3'd3,
      BISHOP = 3'd4,
      QUEEN  = 3'd5,
      KING   = 3'd6
   } chessman_t;

   localparam int WHITE_BIT   = 3;
   localparam int CURSOR_BIT  = 4;
   localparam int LOCK_BIT    = 5;
   localparam int LOCKCUR_BIT = 6;

   localparam logic [15:0] SQ_LIGHT      = 16'hEF5B;
   localparam logic [15:0] SQ_DARK       = 16'hA44A;
   localparam logic [15:0] PIECE_WHITE   = 16'hFFFF;
   localparam logic [15:0] PIECE_BLACK   = 16'h0000;
   localparam logic [15:0] COL_CURSOR    = 16'h07E0;
   localparam logic [15:0] COL_LOCK      = 16'h001F;
   localparam logic [15:0] COL_LOCKCUR   = 16'hFFE0;
   localparam logic [15:0] COL_WIN_WHITE = 16'hF800;
   localparam logic [15:0] COL_WIN_BLACK = 16'h8010;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SNAP   = 2'd1,
      BOARD  = 2'd2,
      STATUS = 2'd3
   } state_t;

endpackage

// File: rtl/chess_board_renderer_if.sv
// Pixel stream interface between the renderer and the display driver.
//   PixelValid / PixelReady : valid/ready handshake, one pixel per accept
//   PixelX, PixelY          : raster coordinate of the pixel on offer
//   PixelData               : RGB565 colour
// master = renderer (pixel source), slave = display driver (pixel sink).
interface chess_board_renderer_if;
   logic        PixelValid;
   logic        PixelReady;
   logic [8:0]  PixelX;
   logic [8:0]  PixelY;
   logic [15:0] PixelData;

   modport master (
      output PixelValid,
      output PixelX,
      output PixelY,
      output PixelData,
      input  PixelReady
   );

   modport slave (
      input  PixelValid,
      input  PixelX,
      input  PixelY,
      input  PixelData,
      output PixelReady
   );
endinterface

// File: rtl/chess_board_renderer_sprite.sv
// Combinational 8x8 one-bit glyph ROM for chessman codes 1..6.
//   sprite_addr : {chessman[2:0], gy[2:0], gx[2:0]}
//   sprite_bit  : 1 where the glyph is drawn; always 0 for codes 0 and 7
// Each glyph is 8 rows of 8 bits, top row in the most significant byte and
// the leftmost pixel in the most significant bit of each row.
module chessman_sprite_rom
   import chess_render_pkg::*;
(
   input  logic [8:0] sprite_addr,
   output logic       sprite_bit
);

   localparam logic [63:0] GLYPH_PAWN   = 64'h0000_183C_3C18_3C7E;
   localparam logic [63:0] GLYPH_KNIGHT = 64'h001C_3E6E_0E1E_3E7E;
   localparam logic [63:0] GLYPH_ROOK   = 64'h005A_7E3C_3C3C_7E7E;
   localparam logic [63:0] GLYPH_BISHOP = 64'h0018_343C_3C18_3C7E;
   localparam logic [63:0] GLYPH_QUEEN  = 64'h005A_5A7E_3C3C_7E7E;
   localparam logic [63:0] GLYPH_KING   = 64'h187E_183C_7E3C_7EFF;

   logic [2:0]  man;
   logic [2:0]  gy;
   logic [2:0]  gx;
   logic [63:0] glyph;
   logic [7:0]  row_bits;

   assign man = sprite_addr[8:6];
   assign gy  = sprite_addr[5:3];
   assign gx  = sprite_addr[2:0];

   always_comb begin
      glyph = 64'h0;
      case (man)
         PAWN:    glyph = GLYPH_PAWN;
         KNIGHT:  glyph = GLYPH_KNIGHT;
         ROOK:    glyph = GLYPH_ROOK;
         BISHOP:  glyph = GLYPH_BISHOP;
         QUEEN:   glyph = GLYPH_QUEEN;
         KING:    glyph = GLYPH_KING;
         default: glyph = 64'h0;
      endcase
   end

   // Row gy sits (7-gy) bytes up from the LSB; ~gy is 7-gy for 3 bits.
   assign row_bits   = glyph[{~gy, 3'b000} +: 8];
   assign sprite_bit = row_bits[~gx];

endmodule

// File: rtl/chess_board_renderer.sv
// Chess board renderer: snapshots the 64-square layout plus Player and
// Checkmate at the start of each frame, then streams the 8x8 board followed
// by a single-colour status strip as RGB565 pixels, one per handshake.
//   clock, reset  : clock, asynchronous active-low reset
//   Layout        : 64 squares x 8 bits, square i = row*8+col at [i*8 +: 8]
//   Player        : 1 = white to move (status colour when not game over)
//   Checkmate     : [0] game over, [1] winning player
//   FrameStart    : frame request, sampled only while idle
//   pix           : pixel stream (master side)
//   FrameBusy     : high from the snapshot cycle until the last acceptance
//   FrameDone     : one-cycle pulse after the last pixel is accepted
module chess_board_renderer
   import chess_render_pkg::*;
#(
   parameter int CHESS_SQUARES = 64,
   parameter int SQUARE_WIDTH  = 8,
   parameter int MATRIX_WIDTH  = CHESS_SQUARES * SQUARE_WIDTH,
   parameter int SQUARE_SHIFT  = 5,
   parameter int STATUS_ROWS   = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [MATRIX_WIDTH-1:0] Layout,
   input  logic                    Player,
   input  logic [1:0]              Checkmate,
   input  logic                    FrameStart,
   chess_board_renderer_if.master  pix,
   output logic                    FrameBusy,
   output logic                    FrameDone
);

   localparam int         BOARD_PX  = 8 << SQUARE_SHIFT;
   localparam logic [8:0] LAST_X    = 9'(BOARD_PX - 1);
   localparam logic [8:0] LAST_Y    = 9'(BOARD_PX + STATUS_ROWS - 1);
   localparam logic [8:0] STATUS_Y0 = 9'(BOARD_PX);

   state_t                  state;
   logic [MATRIX_WIDTH-1:0] snap_layout;
   logic                    snap_player;
   logic [1:0]              snap_cm;
   logic                    valid;
   logic [8:0]              x;
   logic [8:0]              y;
   logic [15:0]             data;

   logic                    accept;
   logic                    last_pix;
   logic                    in_snap;
   logic [MATRIX_WIDTH-1:0] src_layout;
   logic                    src_player;
   logic [1:0]              src_cm;
   logic [8:0]              nx;
   logic [8:0]              ny;
   logic [2:0]              col;
   logic [2:0]              row;
   logic [2:0]              gx;
   logic [2:0]              gy;
   logic [8:0]              sq_base;
   logic [SQUARE_WIDTH-1:0] sq_byte;
   logic                    glyph_on;
   logic [15:0]             next_colour;
   logic                    unused_sq_bit;

   function automatic logic [15:0] square_colour(
      input logic [SQUARE_WIDTH-1:0] sq,
      input logic                    glyph,
      input logic                    dark
   );
      if (glyph)                 return sq[WHITE_BIT] ? PIECE_WHITE : PIECE_BLACK;
      else if (sq[LOCKCUR_BIT])  return COL_LOCKCUR;
      else if (sq[LOCK_BIT])     return COL_LOCK;
      else if (sq[CURSOR_BIT])   return COL_CURSOR;
      else                       return dark ? SQ_DARK : SQ_LIGHT;
   endfunction

   function automatic logic [15:0] status_colour(
      input logic       player,
      input logic [1:0] cm
   );
      if (cm[0]) return cm[1] ? COL_WIN_WHITE : COL_WIN_BLACK;
      else       return player ? PIECE_WHITE : PIECE_BLACK;
   endfunction

   assign accept   = valid & pix.PixelReady;
   assign last_pix = (x == LAST_X) && (y == LAST_Y);
   assign in_snap  = (state == SNAP);

   // The first pixel is coloured in the same cycle the snapshot is taken,
   // so it reads the live inputs; every later pixel reads the snapshot.
   assign src_layout = in_snap ? Layout    : snap_layout;
   assign src_player = in_snap ? Player    : snap_player;
   assign src_cm     = in_snap ? Checkmate : snap_cm;

   always_comb begin
      nx = 9'd0;
      ny = 9'd0;
      if (!in_snap) begin
         if (x == LAST_X) begin
            nx = 9'd0;
            ny = y + 9'd1;
         end else begin
            nx = x + 9'd1;
            ny = y;
         end
      end
   end

   // Colour is computed for the coordinate about to be registered, so data
   // and X/Y leave the same flops together.
   assign col     = nx[SQUARE_SHIFT +: 3];
   assign row     = ny[SQUARE_SHIFT +: 3];
   assign gx      = nx[SQUARE_SHIFT-1 -: 3];
   assign gy      = ny[SQUARE_SHIFT-1 -: 3];
   assign sq_base = {row, col, 3'b000};
   assign sq_byte = src_layout[sq_base +: SQUARE_WIDTH];

   // Bit 7 of each square is reserved and not rendered.
   assign unused_sq_bit = sq_byte[SQUARE_WIDTH-1];

   chessman_sprite_rom u_sprite (
      .sprite_addr ({sq_byte[2:0], gy, gx}),
      .sprite_bit  (glyph_on)
   );

   assign next_colour = (ny >= STATUS_Y0) ? status_colour(src_player, src_cm)
                                          : square_colour(sq_byte, glyph_on, row[0] ^ col[0]);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         snap_layout <= '0;
         snap_player <= 1'b0;
         snap_cm     <= 2'b00;
         valid       <= 1'b0;
         x           <= 9'd0;
         y           <= 9'd0;
         data        <= 16'h0;
         FrameBusy   <= 1'b0;
         FrameDone   <= 1'b0;
      end else begin
         FrameDone <= 1'b0;
         case (state)
            IDLE: begin
               if (FrameStart) begin
                  state     <= SNAP;
                  FrameBusy <= 1'b1;
               end
            end
            SNAP: begin
               snap_layout <= Layout;
               snap_player <= Player;
               snap_cm     <= Checkmate;
               valid       <= 1'b1;
               x           <= 9'd0;
               y           <= 9'd0;
               data        <= next_colour;
               state       <= BOARD;
            end
            BOARD, STATUS: begin
               if (accept) begin
                  if (last_pix) begin
                     valid     <= 1'b0;
                     FrameDone <= 1'b1;
                     FrameBusy <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     x     <= nx;
                     y     <= ny;
                     data  <= next_colour;
                     state <= (ny >= STATUS_Y0) ? STATUS : BOARD;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign pix.PixelValid = valid;
   assign pix.PixelX     = x;
   assign pix.PixelY     = y;
   assign pix.PixelData  = data;

endmodule

// File: doc/chess_board_renderer.md
Name: chess_board_renderer

Overview:
- Consumer of the flattened 64×8 chess layout word, plus the Player and Checkmate outputs, produced by the layout-matrix block.
- Converts them into a raster pixel stream for the display driver.
- Snapshots the layout once per frame, scans the 8×8 board and a status strip, and emits one RGB565 pixel per valid/ready handshake.

Parameters:
- CHESS_SQUARES, 64, number of board squares
- SQUARE_WIDTH, 8, bits per square in Layout
- MATRIX_WIDTH, CHESS_SQUARES*SQUARE_WIDTH, Layout width
- SQUARE_SHIFT, 5, log2 of the square edge in pixels (32 px). Glyph scale is 2^(SQUARE_SHIFT-3).
- STATUS_ROWS, 16, pixel rows of the status strip below the board

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- Layout  in  MATRIX_WIDTH  square i at [i*8 +: 8]; i = row*8+col. Bits: [2:0] chessman (0 empty, 1 pawn, 2 knight, 3 rook, 4 bishop, 5 queen, 6 king), [3] white, [4] cursor, [5] locked source, [6] cursor while locked.
- Player  in  1  1 = white to move
- Checkmate  in  2  [0] game over, [1] winning player
- FrameStart  in  1  request a frame (level or pulse)
- PixelReady  in  1  downstream accepts pixel
- PixelValid  out  1  pixel outputs are valid
- PixelX  out  9  column, 0..BOARD_PX-1
- PixelY  out  9  row, 0..BOARD_PX+STATUS_ROWS-1
- PixelData  out  16  RGB565
- FrameBusy  out  1  frame in progress
- FrameDone  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- BOARD_PX = 8 << SQUARE_SHIFT (256). Reset values: PixelValid=0, PixelX=0, PixelY=0, PixelData=0, FrameBusy=0, FrameDone=0, FSM=IDLE, snapshot registers=0.
- IDLE:
  - FrameStart=1 → SNAP next cycle.
  - FrameBusy=0.
- SNAP (1 cycle):
  - Latch Layout, Player and Checkmate into snapshot registers.
  - X=0, Y=0; → BOARD. FrameBusy=1 from this cycle.
  - All pixels of a frame use the snapshot only; input changes mid-frame have no effect until the next frame.
- BOARD:
  - PixelValid=1. PixelData is a registered function of (X, Y, snapshot); valid in the same cycle as X/Y.
  - Handshake: while PixelValid & !PixelReady, X/Y/Data are held stable.
  - On PixelValid & PixelReady: X++. When X=BOARD_PX-1: X=0, Y++. When Y=BOARD_PX-1 wraps → STATUS.
  - No bubble between accepted pixels: the next pixel is valid the cycle after acceptance.
- Board pixel colour:
  - col = X>>SQUARE_SHIFT, row = Y>>SQUARE_SHIFT.
  - gx, gy = in-square offset >> (SQUARE_SHIFT-3), range 0..7.
  - Glyph bit = sprite(chessman, gy, gx). Chessman 0 or 7 → no glyph.
  - Glyph bit=1 → PIECE_WHITE if bit3 else PIECE_BLACK.
  - Otherwise background, by priority: bit6 → COL_LOCKCUR; else bit5 → COL_LOCK; else bit4 → COL_CURSOR; else (row+col) even → SQ_LIGHT, odd → SQ_DARK.
- STATUS: rows BOARD_PX..BOARD_PX+STATUS_ROWS-1, full width, one colour for the whole strip:
  - Checkmate[0]=1 → COL_WIN_WHITE if Checkmate[1] else COL_WIN_BLACK.
  - Otherwise PIECE_WHITE if Player else PIECE_BLACK.
- On acceptance of the last pixel: PixelValid=0, FrameDone=1 for 1 cycle, FrameBusy=0, → IDLE.
  - FrameStart held high gives back-to-back frames with a 2-cycle gap (IDLE→SNAP).
- FrameStart while FrameBusy=1: ignored, not queued.
- PixelReady while PixelValid=0: ignored.
- reset asserted mid-frame: immediate abort, all outputs take reset values, no FrameDone.
- Counter arithmetic is 9-bit unsigned with no overflow, since the maximum Y is 271.

Decomposition:
- Package chess_render_pkg:
  - Chessman codes (EMPTY..KING).
  - Layout bit positions (WHITE_BIT=3, CURSOR_BIT=4, LOCK_BIT=5, LOCKCUR_BIT=6).
  - RGB565 constants: SQ_LIGHT=16'hEF5B, SQ_DARK=16'hA44A, PIECE_WHITE=16'hFFFF, PIECE_BLACK=16'h0000, COL_CURSOR=16'h07E0, COL_LOCK=16'h001F, COL_LOCKCUR=16'hFFE0, COL_WIN_WHITE=16'hF800, COL_WIN_BLACK=16'h8010.
  - FSM state encoding (IDLE, SNAP, BOARD, STATUS).
- Sub-module chessman_sprite_rom: combinational 8×8 one-bit glyph per chessman code 1..6; input {chessman[2:0], gy[2:0], gx[2:0]}, output 1 bit; 0 for codes 0 and 7.

Test Plan:
- Initial layout, PixelReady=1, one FrameStart pulse → exactly 256×272 = 69632 accepted pixels. First pixel X=0,Y=0; last X=255,Y=271; FrameDone pulses once; FrameBusy drops with it.
- Empty board (all squares 0), Player=1 → pixel (0,0)=SQ_LIGHT, (32,0)=SQ_DARK, (32,32)=SQ_LIGHT, status pixels all 16'hFFFF.
- Square 27 = 8'h7E (lock+cursor, white king) → glyph-on pixels in square 27 = 16'hFFFF, others = 16'hFFE0. Same square with 8'h1E → background 16'h07E0.
- PixelReady toggled randomly, 30% duty → X/Y/Data never change while PixelValid & !PixelReady; pixel count and order identical to the full-ready case.
- Layout changed at pixel 1000 and FrameStart pulsed mid-frame → remaining frame uses the old snapshot; no second frame starts.
- Checkmate=2'b11 → status strip all 16'hF800. reset driven low at pixel 5000 → next cycle PixelValid=0, FrameBusy=0, no FrameDone; a fresh FrameStart restarts at (0,0).
